// File: rtl/yc_noc_defs.sv
// ---------------------------------------------------------------------------
// yc_noc_defs -- shared NoC definitions.
//   SEQ_W, TS_W      : sequence-number and timestamp widths
//   COORD_W          : width of each mesh coordinate field
//   PAYLOAD_W        : flit payload width
//   flit_t           : packed flit {dst_x, dst_y, src_x, src_y, seq, ts, payload}
//   rx_stall_e       : receive backpressure FSM states {RDY, STALL}
// ---------------------------------------------------------------------------
package yc_noc_defs;

  localparam int SEQ_W     = 16;
  localparam int TS_W      = 16;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [COORD_W-1:0]   src_x;
    logic [COORD_W-1:0]   src_y;
    logic [SEQ_W-1:0]     seq;
    logic [TS_W-1:0]      ts;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    RDY   = 1'b0,
    STALL = 1'b1
  } rx_stall_e;

endpackage

// File: rtl/yc_niu_rx_seqchk.sv
// ---------------------------------------------------------------------------
// yc_niu_rx_seqchk -- per-source sequence continuity tracker.
// One entry per mesh node (index src_y*MAX_X + src_x) holding a seen bit and
// the next expected sequence number. The checker always resyncs to seq+1.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears seen bits)
//   chk_valid   : a flit is in the check stage this cycle
//   src_x/src_y : source coordinates of that flit
//   seq         : its sequence number
//   src_ok      : source coordinates lie inside the MAX_X x MAX_Y mesh
//   seq_err     : flit is a discontinuity (valid only when chk_valid)
// ---------------------------------------------------------------------------
module yc_niu_rx_seqchk
  import yc_noc_defs::*;
#(
  parameter int MAX_X = 4,
  parameter int MAX_Y = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               chk_valid,
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  input  logic [SEQ_W-1:0]   seq,
  output logic               src_ok,
  output logic               seq_err
);

  localparam int N     = MAX_X * MAX_Y;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     seen_q;
  logic [SEQ_W-1:0] exp_q [N];
  logic [IDX_W-1:0] idx;
  logic             upd;
  int               idx_i;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held (no latch); sequential
  // blocks use '<=' only.
  always_comb begin
    src_ok  = (int'(src_x) < MAX_X) && (int'(src_y) < MAX_Y);
    idx_i   = int'(src_y) * MAX_X + int'(src_x);
    idx     = src_ok ? IDX_W'(idx_i) : '0;
    upd     = chk_valid && src_ok;
    seq_err = upd && seen_q[idx] && (seq != exp_q[idx]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= '0;
    end else if (upd) begin
      seen_q[idx] <= 1'b1;
    end
  end

  // NOTE: the expected-seq array is a memory and is not reset; an entry is
  // only ever read once its seen bit (which is reset) has been set.
  always_ff @(posedge clk) begin
    if (upd) begin
      exp_q[idx] <= seq + SEQ_W'(1);
    end
  end

endmodule

// File: rtl/yc_niu_rx.sv
// ---------------------------------------------------------------------------
// yc_niu_rx -- NoC receive (ejection) endpoint.
// Accepts flits from a router local output under programmable backpressure,
// registers each accepted flit into a one-deep check stage, then checks the
// destination and the per-source sequence and updates saturating counters.
// Optional build macro YC_NIU_RX_LAT_EN adds latency statistics from the
// flit ts field against a free-running cycle counter.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   rx_valid       : flit valid from router
//   rx_flit        : flit from router
//   rx_ready       : sink ready (straight from a flop)
//   rx_count       : flits accepted (saturating)
//   err_dst_count  : flits with wrong destination or out-of-range source
//   err_seq_count  : sequence discontinuities
//   err_pulse      : one-cycle pulse per flit with any error
//   last_flit      : most recently checked flit
//   last_valid     : last_flit holds a real flit
//   lat_min/lat_max/lat_sum : latency stats (YC_NIU_RX_LAT_EN only)
// ---------------------------------------------------------------------------
module yc_niu_rx
  import yc_noc_defs::*;
#(
  parameter int MY_X         = 0,
  parameter int MY_Y         = 0,
  parameter int MAX_X        = 4,
  parameter int MAX_Y        = 4,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_CYC    = 0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  flit_t            rx_flit,
  output logic             rx_ready,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_dst_count,
  output logic [CNT_W-1:0] err_seq_count,
  output logic             err_pulse,
  output flit_t            last_flit,
  output logic             last_valid
`ifdef YC_NIU_RX_LAT_EN
  ,
  output logic [TS_W-1:0]  lat_min,
  output logic [TS_W-1:0]  lat_max,
  output logic [CNT_W-1:0] lat_sum
`endif
);

  localparam int PH_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- backpressure FSM ----------------
  // The state register resets to STALL so rx_ready is low in reset and rises
  // on the first clock edge with rst_n high. The phase counter leads the
  // state by one edge: state after edge k reflects phase k-1.
  rx_stall_e       state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STALL;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = RDY;
    phase_d = '0;
    if (STALL_PERIOD > 1 && int'(phase_q) != STALL_PERIOD - 1) begin
      phase_d = phase_q + PH_ONE;
    end
    if (STALL_PERIOD > 0 && STALL_CYC > 0 &&
        int'(phase_q) >= STALL_PERIOD - STALL_CYC) begin
      state_d = STALL;
    end
  end

  always_comb begin
    rx_ready = (state_q == RDY);
  end

  // ---------------- check stage ----------------
  logic  chk_valid_q;
  flit_t chk_flit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_valid_q <= 1'b0;
      chk_flit_q  <= '0;
    end else begin
      chk_valid_q <= rx_valid && rx_ready;
      if (rx_valid && rx_ready) begin
        chk_flit_q <= rx_flit;
      end
    end
  end

  logic src_ok, seq_err, dst_err;

  yc_niu_rx_seqchk #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_seqchk (
    .clk       (clk),
    .rst_n     (rst_n),
    .chk_valid (chk_valid_q),
    .src_x     (chk_flit_q.src_x),
    .src_y     (chk_flit_q.src_y),
    .seq       (chk_flit_q.seq),
    .src_ok    (src_ok),
    .seq_err   (seq_err)
  );

  // An out-of-range source cannot be tracked, so it is reported as a
  // routing (destination) error instead.
  always_comb begin
    dst_err = chk_valid_q &&
              ((int'(chk_flit_q.dst_x) != MY_X) ||
               (int'(chk_flit_q.dst_y) != MY_Y) || !src_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_count      <= '0;
      err_dst_count <= '0;
      err_seq_count <= '0;
      err_pulse     <= 1'b0;
      last_flit     <= '0;
      last_valid    <= 1'b0;
    end else begin
      err_pulse <= dst_err || seq_err;
      if (chk_valid_q) begin
        last_flit  <= chk_flit_q;
        last_valid <= 1'b1;
        if (rx_count != '1) rx_count <= rx_count + CNT_ONE;
      end
      if (dst_err && err_dst_count != '1) err_dst_count <= err_dst_count + CNT_ONE;
      if (seq_err && err_seq_count != '1) err_seq_count <= err_seq_count + CNT_ONE;
    end
  end

`ifdef YC_NIU_RX_LAT_EN
  // ---------------- latency statistics ----------------
  logic [TS_W-1:0]  now_q;
  logic [TS_W-1:0]  lat;
  logic [CNT_W:0]   sum_ext;

  always_comb begin
    lat     = now_q - chk_flit_q.ts;
    sum_ext = {1'b0, lat_sum} + (CNT_W + 1)'(lat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_q   <= '0;
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      now_q <= now_q + TS_W'(1);
      if (chk_valid_q) begin
        if (lat < lat_min) lat_min <= lat;
        if (lat > lat_max) lat_max <= lat;
        lat_sum <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_yc_niu_rx.sv
// ---------------------------------------------------------------------------
// tb_yc_niu_rx -- directed bench for yc_niu_rx.
// dut   : default parameters (always ready, MY=(0,0), 4x4 mesh)
// dut_s : STALL_PERIOD=4, STALL_CYC=1
// Inputs change and outputs are read on the falling edge.
// ---------------------------------------------------------------------------
module tb_yc_niu_rx;
  import yc_noc_defs::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic             rst_n, rx_valid, rx_ready, err_pulse, last_valid;
  flit_t            rx_flit, last_flit;
  logic [CNT_W-1:0] rx_count, err_dst_count, err_seq_count;
  // stall instance
  logic             rst_n_s, rx_valid_s, rx_ready_s, err_pulse_s, last_valid_s;
  flit_t            rx_flit_s, last_flit_s;
  logic [CNT_W-1:0] rx_count_s, err_dst_count_s, err_seq_count_s;
`ifdef YC_NIU_RX_LAT_EN
  logic [TS_W-1:0]  lat_min, lat_max, lat_min_s, lat_max_s;
  logic [CNT_W-1:0] lat_sum, lat_sum_s;
  logic [TS_W-1:0]  tb_now;
  always @(posedge clk) tb_now <= !rst_n ? '0 : tb_now + TS_W'(1);
`endif

  yc_niu_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_flit(rx_flit),
    .rx_ready(rx_ready), .rx_count(rx_count), .err_dst_count(err_dst_count),
    .err_seq_count(err_seq_count), .err_pulse(err_pulse),
    .last_flit(last_flit), .last_valid(last_valid)
`ifdef YC_NIU_RX_LAT_EN
    , .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
`endif
  );

  yc_niu_rx #(.STALL_PERIOD(4), .STALL_CYC(1)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .rx_valid(rx_valid_s), .rx_flit(rx_flit_s),
    .rx_ready(rx_ready_s), .rx_count(rx_count_s), .err_dst_count(err_dst_count_s),
    .err_seq_count(err_seq_count_s), .err_pulse(err_pulse_s),
    .last_flit(last_flit_s), .last_valid(last_valid_s)
`ifdef YC_NIU_RX_LAT_EN
    , .lat_min(lat_min_s), .lat_max(lat_max_s), .lat_sum(lat_sum_s)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;

  // err_pulse is read before the DUT updates it at each rising edge, so
  // every completed high cycle is counted exactly once.
  always @(posedge clk) if (err_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input int dx, input int dy, input int sx,
                               input int sy, input int sq, input int ts);
    flit_t f;
    f.dst_x   = COORD_W'(dx);
    f.dst_y   = COORD_W'(dy);
    f.src_x   = COORD_W'(sx);
    f.src_y   = COORD_W'(sy);
    f.seq     = SEQ_W'(sq);
    f.ts      = TS_W'(ts);
    f.payload = 32'hA500_0000 | 32'(sq);
    return f;
  endfunction

  // Offer one flit on dut; returns on the falling edge after the transfer
  // with rx_valid still high so back-to-back calls give full throughput.
  task automatic send(input flit_t f);
    int n = 0;
    rx_valid = 1'b1;
    rx_flit  = f;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n, lows;
    logic r;
    logic [7:0] low_mask;
    rst_n = 1'b0; rx_valid = 1'b0; rx_flit = '0;
    rst_n_s = 1'b0; rx_valid_s = 1'b0; rx_flit_s = '0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_ready", rx_ready, 0);
    check("rst_count", rx_count, 0);
    check("rst_last_valid", last_valid, 0);
    check("rst_last_flit", last_flit, 0);
    check("rst_pulse", err_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", rx_ready, 1);

    // ---- 20 in-order flits from (1,0) ----
    for (int i = 0; i < 20; i++) send(mk(0, 0, 1, 0, i, 0));
    idle(2);
    check("t1_count", rx_count, 20);
    check("t1_err_dst", err_dst_count, 0);
    check("t1_err_seq", err_seq_count, 0);
    check("t1_last_seq", last_flit.seq, 19);
    check("t1_last_src", last_flit.src_x, 1);
    check("t1_last_valid", last_valid, 1);
    check("t1_pulses", pulse_cnt, 0);

    // ---- seq gap 5,6,8,9 ----
    do_reset();
    p0 = pulse_cnt;
    send(mk(0, 0, 1, 0, 5, 0));
    send(mk(0, 0, 1, 0, 6, 0));
    send(mk(0, 0, 1, 0, 8, 0));
    check("gap_pulse_pre", err_pulse, 0);
    send(mk(0, 0, 1, 0, 9, 0));
    check("gap_pulse_at8", err_pulse, 1);
    idle(1);
    check("gap_pulse_at9", err_pulse, 0);
    idle(1);
    check("gap_err_seq", err_seq_count, 1);
    check("gap_count", rx_count, 4);
    check("gap_pulses", pulse_cnt - p0, 1);

    // ---- misrouted flit ----
    do_reset();
    p0 = pulse_cnt;
    send(mk(1, 1, 0, 1, 0, 0));
    idle(2);
    check("dst_err_dst", err_dst_count, 1);
    check("dst_count", rx_count, 1);
    check("dst_err_seq", err_seq_count, 0);
    check("dst_pulses", pulse_cnt - p0, 1);

    // ---- out-of-range source, then a double error ----
    send(mk(0, 0, 5, 0, 3, 0));
    idle(2);
    check("oor_err_dst", err_dst_count, 2);
    check("oor_err_seq", err_seq_count, 0);
    p0 = pulse_cnt;
    send(mk(0, 0, 2, 2, 10, 0));
    send(mk(1, 0, 2, 2, 20, 0));   // wrong dst and expected 11
    idle(2);
    check("both_err_dst", err_dst_count, 3);
    check("both_err_seq", err_seq_count, 1);
    check("both_pulses", pulse_cnt - p0, 1);

    // ---- sequence wrap ----
    do_reset();
    send(mk(0, 0, 3, 3, 65534, 0));
    send(mk(0, 0, 3, 3, 65535, 0));
    send(mk(0, 0, 3, 3, 0, 0));
    send(mk(0, 0, 3, 3, 1, 0));
    idle(2);
    check("wrap_err_seq", err_seq_count, 0);
    check("wrap_count", rx_count, 4);
    check("wrap_last_seq", last_flit.seq, 1);

    // ---- reset mid-stream ----
    do_reset();
    send(mk(0, 0, 1, 0, 0, 0));
    send(mk(0, 0, 1, 0, 5, 0));
    send(mk(0, 0, 1, 0, 6, 0));
    check("mid_pre_err_seq", err_seq_count, 1);
    check("mid_pre_count", rx_count, 2);
    rx_flit = mk(0, 0, 1, 0, 7, 0);      // rx_valid stays high into reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_count", rx_count, 0);
    check("mid_rst_err_seq", err_seq_count, 0);
    check("mid_rst_ready", rx_ready, 0);
    check("mid_rst_last_valid", last_valid, 0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send(mk(0, 0, 1, 0, 100, 0));
    send(mk(0, 0, 1, 0, 101, 0));
    idle(2);
    check("mid_post_err_seq", err_seq_count, 0);
    check("mid_post_count", rx_count, 2);
    check("mid_post_last_seq", last_flit.seq, 101);

`ifdef YC_NIU_RX_LAT_EN
    // ---- latency: 3 and 7 cycles ----
    do_reset();
    check("lat_rst_min", lat_min, 16'hFFFF);
    check("lat_rst_max", lat_max, 0);
    send(mk(0, 0, 0, 0, 0, int'(tb_now) - 2));
    send(mk(0, 0, 0, 0, 1, int'(tb_now) - 6));
    idle(2);
    check("lat_min", lat_min, 3);
    check("lat_max", lat_max, 7);
    check("lat_sum", lat_sum, 10);
`endif

    // ---- backpressure 1 in 4, valid held 100 cycles ----
    rst_n_s = 1'b1;
    @(negedge clk);
    n = 0; lows = 0; low_mask = '0;
    for (int i = 0; i < 100; i++) begin
      rx_valid_s = 1'b1;
      rx_flit_s  = mk(0, 0, 1, 0, n, 0);
      r = rx_ready_s;
      if (!r) lows++;
      if (i < 8) low_mask[i] = !r;
      @(negedge clk);
      if (r) n++;
    end
    rx_valid_s = 1'b0;
    repeat (2) @(negedge clk);
    check("stall_low_cycles", lows, 25);
    check("stall_pattern", low_mask, 8'b1000_1000);
    check("stall_count", rx_count_s, 75);
    check("stall_err_seq", err_seq_count_s, 0);
    check("stall_err_dst", err_dst_count_s, 0);
    check("stall_last_seq", last_flit_s.seq, 74);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
